// File: rtl/rv_pkg.sv
// Shared types and sizes for the write-back path.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    // Identity of the most recent write-back winner.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    // Bit positions of each requester in the arbiter request/grant vectors.
    localparam int unsigned ARB_ALU = 0;
    localparam int unsigned ARB_LSU = 1;

    // The requester that is not s; the round-robin winner after s was served.
    function automatic wb_src_e wb_other(input wb_src_e s);
        return (s == WB_ALU) ? WB_LSU : WB_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Producer, issue-stage and register-file signals of the write-back controller.
interface regfile_wb_ctrl_if #(
    parameter int unsigned XLEN = rv_pkg::XLEN,
    parameter int unsigned AW   = rv_pkg::AW
) ();

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_busy;
    logic            rs2_busy;

    logic            reg_write;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rslt_data;

    // Producer / issue side of the controller.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
        input  reg_write, rd, rslt_data
    );

    // The controller itself.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
        output reg_write, rd, rslt_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; one-hot grant, remembers the last winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    import rv_pkg::*;

    wb_src_e last_q;
    wb_src_e last_d;
    wb_src_e winner;

    // Last-winner register; LSU after reset so the ALU takes the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= WB_LSU;
        end else begin
            last_q <= last_d;
        end
    end

    // Grant selection and last-winner update; no grant at all while in reset.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        winner = wb_other(last_q);
        if (rst_n) begin
            if (req[ARB_ALU] && req[ARB_LSU]) begin
                gnt[ARB_ALU] = (winner == WB_ALU);
                gnt[ARB_LSU] = (winner == WB_LSU);
            end else begin
                gnt = req;
            end
            if (gnt[ARB_ALU]) begin
                last_d = WB_ALU;
            end else if (gnt[ARB_LSU]) begin
                last_d = WB_LSU;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: arbitrates ALU/LSU onto the single
// write port and tracks pending destinations for hazard detection.
module regfile_wb_ctrl #(
    parameter int unsigned XLEN = rv_pkg::XLEN,
    parameter int unsigned NREG = rv_pkg::NREG,
    parameter int unsigned AW   = rv_pkg::AW
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wb_ctrl_if.slave  bus
);

    import rv_pkg::*;

    localparam logic [AW-1:0] X0 = AW'(0);

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            any_gnt;
    logic [AW-1:0]   g_rd;
    logic [XLEN-1:0] g_data;

    logic            reg_write_q;
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] rslt_data_q;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            issue_ok;
    logic            issue_set;

    assign req[ARB_ALU] = bus.alu_valid;
    assign req[ARB_LSU] = bus.lsu_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus.alu_ready = gnt[ARB_ALU];
    assign bus.lsu_ready = gnt[ARB_LSU];
    assign any_gnt       = |gnt;

    // Payload of the granted requester.
    always_comb begin
        g_rd   = bus.alu_rd;
        g_data = bus.alu_data;
        if (gnt[ARB_LSU]) begin
            g_rd   = bus.lsu_rd;
            g_data = bus.lsu_data;
        end
    end

    // Registered write port; x0 grants are consumed but never enable a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            rd_q        <= X0;
            rslt_data_q <= XLEN'(0);
        end else if (any_gnt) begin
            reg_write_q <= (g_rd != X0);
            rd_q        <= g_rd;
            rslt_data_q <= g_data;
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    assign bus.reg_write = reg_write_q;
    assign bus.rd        = rd_q;
    assign bus.rslt_data = rslt_data_q;

    // Dispatch is blocked only by a pending write to the same non-zero register.
    assign issue_ok        = (bus.issue_rd == X0) || !busy_q[bus.issue_rd];
    assign bus.issue_ready = rst_n && issue_ok;
    assign issue_set       = bus.issue_valid && bus.issue_ready && (bus.issue_rd != X0);

    // Scoreboard update: clear on write-back, then set on issue so a same-edge
    // re-issue keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register; reset discards every pending entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.rs1_busy = busy_q[bus.rs1];
    assign bus.rs2_busy = busy_q[bus.rs2];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a cycle-level reference model.
module tb_regfile_wb_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    logic clk;
    logic rst_n;

    regfile_wb_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_wb_ctrl #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Register file fed by the write port; writes whatever it is told to.
    logic [31:0] rf [NREG] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.reg_write) rf[bus.rd] <= bus.rslt_data;
    end

    // Reference model state: expected outputs after the most recent edge.
    bit          m_init = 1'b0;
    int          m_last = 1;             // 0 = ALU won last, 1 = LSU won last
    bit          m_busy [NREG];
    bit          m_wr   = 1'b0;
    int          m_rd   = 0;
    logic [31:0] m_data = 32'h0;

    // Compare DUT to the model mid-cycle, then advance the model over the next edge.
    always @(negedge clk) begin : compare
        int g;
        bit iss_ok;
        int grd;
        logic [31:0] gdata;
        if (!rst_n)                              g = -1;
        else if (bus.alu_valid && bus.lsu_valid) g = (m_last == 1) ? 0 : 1;
        else if (bus.alu_valid)                  g = 0;
        else if (bus.lsu_valid)                  g = 1;
        else                                     g = -1;
        iss_ok = rst_n && (bus.issue_rd == 0 || !m_busy[bus.issue_rd]);
        if (m_init) begin
            check("alu_ready",   32'(bus.alu_ready),   32'(g == 0));
            check("lsu_ready",   32'(bus.lsu_ready),   32'(g == 1));
            check("issue_ready", 32'(bus.issue_ready), 32'(iss_ok));
            check("rs1_busy",    32'(bus.rs1_busy),    32'(m_busy[bus.rs1]));
            check("rs2_busy",    32'(bus.rs2_busy),    32'(m_busy[bus.rs2]));
            check("reg_write",   32'(bus.reg_write),   32'(m_wr));
            check("rd",          32'(bus.rd),          32'(m_rd));
            check("rslt_data",   bus.rslt_data,        m_data);
        end
        if (!rst_n) begin
            m_last = 1;
            m_wr   = 1'b0;
            m_rd   = 0;
            m_data = 32'h0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            if (m_wr) m_busy[m_rd] = 1'b0;
            if (bus.issue_valid && iss_ok && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
            if (g >= 0) begin
                grd    = (g == 0) ? int'(bus.alu_rd) : int'(bus.lsu_rd);
                gdata  = (g == 0) ? bus.alu_data : bus.lsu_data;
                m_wr   = (grd != 0);
                m_rd   = grd;
                m_data = gdata;
                m_last = g;
            end else begin
                m_wr = 1'b0;
            end
        end
        m_init = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic a_acc;
    logic l_acc;

    initial begin
        rst_n           = 1'b0;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd1;
        bus.alu_data    = 32'h11;
        bus.lsu_valid   = 1'b1;
        bus.lsu_rd      = 5'd6;
        bus.lsu_data    = 32'h66;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.rs1         = 5'd7;
        bus.rs2         = 5'd3;

        // Reset held two cycles with requests pending.
        cyc(); cyc(); mid();
        check("rst reg_write",   32'(bus.reg_write),   32'd0);
        check("rst rd",          32'(bus.rd),          32'd0);
        check("rst rslt_data",   bus.rslt_data,        32'd0);
        check("rst alu_ready",   32'(bus.alu_ready),   32'd0);
        check("rst lsu_ready",   32'(bus.lsu_ready),   32'd0);
        check("rst issue_ready", 32'(bus.issue_ready), 32'd0);
        check("rst rs2_busy",    32'(bus.rs2_busy),    32'd0);
        cyc();
        rst_n = 1'b1; bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0; bus.issue_valid = 1'b0;

        // Single ALU write to x2.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
        mid(); check("single alu_ready", 32'(bus.alu_ready), 32'd1);
        cyc(); bus.alu_valid = 1'b0;
        mid();
        check("single reg_write", 32'(bus.reg_write), 32'd1);
        check("single rd",        32'(bus.rd),        32'd2);
        check("single data",      bus.rslt_data,      32'h2);
        cyc(); mid();
        check("single rf x2",   rf[2],              32'h2);
        check("idle reg_write", 32'(bus.reg_write), 32'd0);
        check("idle rd hold",   32'(bus.rd),        32'd2);

        // Conflict directly after a reset: ALU, LSU, ALU.
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hB;
        mid();
        check("conf1 alu_ready", 32'(bus.alu_ready), 32'd1);
        check("conf1 lsu_ready", 32'(bus.lsu_ready), 32'd0);
        cyc(); mid();
        check("conf2 alu_ready", 32'(bus.alu_ready), 32'd0);
        check("conf2 lsu_ready", 32'(bus.lsu_ready), 32'd1);
        check("conf2 rd",        32'(bus.rd),        32'd3);
        check("conf2 data",      bus.rslt_data,      32'hA);
        cyc(); bus.lsu_valid = 1'b0;
        mid();
        check("conf3 alu_ready", 32'(bus.alu_ready), 32'd1);
        check("conf3 rd",        32'(bus.rd),        32'd4);
        check("conf3 data",      bus.rslt_data,      32'hB);
        cyc(); bus.alu_valid = 1'b0;
        mid();
        check("conf4 reg_write", 32'(bus.reg_write), 32'd1);
        check("conf4 rd",        32'(bus.rd),        32'd3);

        // LSU write to x0 is consumed but never written.
        cyc(); bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFF_FFFF;
        mid(); check("x0 lsu_ready", 32'(bus.lsu_ready), 32'd1);
        cyc(); bus.lsu_valid = 1'b0;
        mid(); check("x0 reg_write", 32'(bus.reg_write), 32'd0);
        cyc(); mid(); check("x0 rf", rf[0], 32'h0);

        // Scoreboard set, WAW block, clear after write-back.
        cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd7;
        mid();
        check("sb issue_ready", 32'(bus.issue_ready), 32'd1);
        check("sb rs1_busy0",   32'(bus.rs1_busy),    32'd0);
        cyc(); mid();
        check("sb rs1_busy1",   32'(bus.rs1_busy),    32'd1);
        check("sb waw block",   32'(bus.issue_ready), 32'd0);
        cyc(); bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        mid(); check("sb alu_ready", 32'(bus.alu_ready), 32'd1);
        cyc(); bus.alu_valid = 1'b0;
        mid();
        check("sb wb reg_write", 32'(bus.reg_write), 32'd1);
        check("sb wb busy held", 32'(bus.rs1_busy),  32'd1);
        cyc(); mid(); check("sb cleared", 32'(bus.rs1_busy), 32'd0);

        // Re-issue on the same edge as the clear keeps the register pending.
        cyc(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h70;
        mid();
        cyc(); bus.alu_valid = 1'b0; bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        mid();
        check("same-edge reg_write",   32'(bus.reg_write),   32'd1);
        check("same-edge issue_ready", 32'(bus.issue_ready), 32'd1);
        cyc(); bus.issue_valid = 1'b0;
        mid(); check("same-edge busy", 32'(bus.rs1_busy), 32'd1);

        // Reset in the middle of a pending write and scoreboard entry.
        cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs2 = 5'd5;
        mid();
        cyc(); bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h55;
        mid(); check("mid rs2_busy", 32'(bus.rs2_busy), 32'd1);
        cyc(); bus.alu_valid = 1'b0; rst_n = 1'b0;
        mid(); check("mid inflight", 32'(bus.reg_write), 32'd1);
        cyc(); rst_n = 1'b1;
        mid();
        check("mid post reg_write", 32'(bus.reg_write), 32'd0);
        check("mid post busy5",     32'(bus.rs2_busy),  32'd0);
        check("mid post busy7",     32'(bus.rs1_busy),  32'd0);

        // Sustained dual requests; each side advances its payload once accepted.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd8;  bus.alu_data = 32'h800;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd16; bus.lsu_data = 32'h1600;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.rs1 = 5'd9; bus.rs2 = 5'd16;
        for (int i = 0; i < 8; i++) begin
            mid();
            a_acc = bus.alu_ready;
            l_acc = bus.lsu_ready;
            cyc();
            bus.issue_valid = 1'b0;
            if (a_acc) begin
                bus.alu_rd   = bus.alu_rd + 5'd1;
                bus.alu_data = bus.alu_data + 32'h1;
            end
            if (l_acc) begin
                bus.lsu_rd   = bus.lsu_rd + 5'd1;
                bus.lsu_data = bus.lsu_data + 32'h1;
            end
        end
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        cyc(); mid();
        check("stream rf x9", rf[9], 32'h801);
        cyc(); mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
